// File: rtl/ca_rule_gen_pkg.sv
// ----------------------------------------------------------------------------
// ca_pkg: shared definitions for the elementary cellular-automaton generator.
//   - default geometry (cells per word, words per row, RAM address width)
//   - controller state encoding
//   - seed_cell(): index of the single live cell in a seed row
// ----------------------------------------------------------------------------
package ca_pkg;

    localparam int unsigned DEF_WORD_W    = 32'd16;
    localparam int unsigned DEF_ROW_WORDS = 32'd80;
    localparam int unsigned DEF_ADDR_W    = 32'd10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        READ     = 3'd2,
        FLUSH    = 3'd3,
        SEED     = 3'd4,
        DONE     = 3'd5
    } ca_state_e;

    // The seed row has one live cell in the middle of the row.
    function automatic int unsigned seed_cell(input int unsigned row_cells);
        return row_cells / 32'd2;
    endfunction

endpackage

// File: rtl/ca_rule_gen_if.sv
// ----------------------------------------------------------------------------
// ca_rule_gen_if: row RAM port used by the generator.
//   read/raddr  : read request, data returned on rdata one cycle later
//   write/waddr/wdata : single-cycle write
//   master = generator, slave = RAM
// ----------------------------------------------------------------------------
interface ca_rule_gen_if
    import ca_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              read;
    logic [ADDR_W-1:0] raddr;
    logic [WORD_W-1:0] rdata;
    logic              write;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;

    modport master (
        output read, raddr, write, waddr, wdata,
        input  rdata
    );

    modport slave (
        input  read, raddr, write, waddr, wdata,
        output rdata
    );
endinterface

// File: rtl/ca_rule_word.sv
// ----------------------------------------------------------------------------
// ca_rule_word: applies an elementary rule to every cell of one word.
//   rule     : Wolfram rule number; new cell = rule[{L,C,R}]
//   left     : cell immediately left of word bit 0
//   word     : current cells, bit 0 is the leftmost cell
//   right    : cell immediately right of word bit WORD_W-1
//   new_word : next-generation cells
// Purely combinational.
// ----------------------------------------------------------------------------
module ca_rule_word
    import ca_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic [7:0]        rule,
    input  logic              left,
    input  logic [WORD_W-1:0] word,
    input  logic              right,
    output logic [WORD_W-1:0] new_word
);

    // ext_s[0] is the left neighbour, ext_s[WORD_W+1] the right neighbour.
    logic [WORD_W+1:0] ext_s;

    // Evaluate the rule for each cell from its three-cell neighbourhood.
    always_comb begin
        ext_s    = {right, word, left};
        new_word = '0;
        for (int b = 0; b < int'(WORD_W); b++) begin
            new_word[b] = rule[{ext_s[b], ext_s[b+1], ext_s[b+2]}];
        end
    end

endmodule

// File: rtl/ca_rule_gen.sv
// ----------------------------------------------------------------------------
// ca_rule_gen: computes one generation of an elementary cellular automaton,
// streaming a row word by word from one RAM bank into the other.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle request; direction/seed/rule/wrap sampled with it
//   direction : source bank (destination is the other bank)
//   seed      : write the seed row instead of computing
//   rule      : Wolfram rule number
//   wrap      : 1 = periodic row, 0 = zero cells beyond both ends
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   ram       : row RAM port (1-cycle read latency)
// Compute run: the last word is read first so the left neighbour of word 0 is
// known, then words 0..ROW_WORDS-1. Each word is written once its right-hand
// word has arrived; word 0 is kept so the last word needs no extra read.
// ROW_WORDS must be at least 2.
// ----------------------------------------------------------------------------
module ca_rule_gen
    import ca_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned ROW_WORDS = DEF_ROW_WORDS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          direction,
    input  logic          seed,
    input  logic [7:0]    rule,
    input  logic          wrap,
    output logic          busy,
    output logic          done,
    ca_rule_gen_if.master ram
);

    localparam int unsigned IDX_W    = ADDR_W - 32'd1;
    localparam int unsigned CNT_W    = $clog2(ROW_WORDS + 32'd1);
    localparam int unsigned SEED_C   = seed_cell(ROW_WORDS * WORD_W);
    localparam int unsigned SEED_IDX = SEED_C / WORD_W;
    localparam int unsigned SEED_BIT = SEED_C % WORD_W;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_WORDS - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ROW  = CNT_W'(ROW_WORDS);
    localparam logic [CNT_W-1:0] CNT_SEED = CNT_W'(SEED_IDX);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROW_WORDS - 32'd1);

    ca_state_e         state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              read_r;
    logic              write_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] raddr_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [WORD_W-1:0] wdata_r;
    logic [WORD_W-1:0] word0_r;
    logic [WORD_W-1:0] cur_r;
    logic              left_r;
    logic              dir_r;
    logic              wrap_r;
    logic [7:0]        rule_r;

    logic              pre_arr_s;
    logic              first_arr_s;
    logic              arr_s;
    logic              fin_s;
    logic              right_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [WORD_W-1:0] new_word_s;

    // Seed row content for word idx: a single 1 at the middle cell.
    function automatic logic [WORD_W-1:0] seed_word(input logic [CNT_W-1:0] idx);
        logic [WORD_W-1:0] w;
        w = '0;
        if (idx == CNT_SEED) begin
            w[SEED_BIT] = 1'b1;
        end else begin
            w = '0;
        end
        return w;
    endfunction

    // Classify what rdata carries this cycle and choose the right neighbour.
    // READ cnt 0 sees the prefetched last word, READ cnt 1 sees word 0, later
    // READ cycles and FLUSH cnt 0 see words 1..ROW_WORDS-1, FLUSH cnt 1 is
    // the last word's turn (no data on rdata).
    always_comb begin
        pre_arr_s   = 1'b0;
        first_arr_s = 1'b0;
        arr_s       = 1'b0;
        fin_s       = 1'b0;
        case (state_r)
            READ: begin
                pre_arr_s   = (cnt_r == CNT_ZERO);
                first_arr_s = (cnt_r == CNT_ONE);
                arr_s       = (cnt_r > CNT_ONE);
            end
            FLUSH: begin
                arr_s = (cnt_r == CNT_ZERO);
                fin_s = (cnt_r == CNT_ONE);
            end
            default: begin
                pre_arr_s   = 1'b0;
                first_arr_s = 1'b0;
                arr_s       = 1'b0;
                fin_s       = 1'b0;
            end
        endcase
        if (fin_s) begin
            right_s = wrap_r & word0_r[0];
        end else begin
            right_s = ram.rdata[0];
        end
        // Writes within a run are contiguous, so the next index follows the last.
        if (write_r) begin
            wr_idx_s = waddr_r[IDX_W-1:0] + IDX_ONE;
        end else begin
            wr_idx_s = IDX_ZERO;
        end
    end

    ca_rule_word #(
        .WORD_W (WORD_W)
    ) u_rule_word (
        .rule     (rule_r),
        .left     (left_r),
        .word     (cur_r),
        .right    (right_s),
        .new_word (new_word_s)
    );

    // Controller FSM, word counter, word pipeline and registered RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            raddr_r <= '0;
            waddr_r <= '0;
            wdata_r <= '0;
            word0_r <= '0;
            cur_r   <= '0;
            left_r  <= 1'b0;
            dir_r   <= 1'b0;
            wrap_r  <= 1'b0;
            rule_r  <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (start) begin
                        dir_r  <= direction;
                        wrap_r <= wrap;
                        rule_r <= rule;
                        busy_r <= 1'b1;
                        if (seed) begin
                            state_r <= SEED;
                            write_r <= 1'b1;
                            waddr_r <= {~direction, IDX_ZERO};
                            wdata_r <= seed_word(CNT_ZERO);
                            cnt_r   <= CNT_ONE;
                        end else begin
                            state_r <= PREFETCH;
                            read_r  <= 1'b1;
                            raddr_r <= {direction, IDX_LAST};
                            cnt_r   <= CNT_ZERO;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                PREFETCH: begin
                    state_r <= READ;
                    read_r  <= 1'b1;
                    write_r <= 1'b0;
                    raddr_r <= {dir_r, IDX_ZERO};
                    cnt_r   <= CNT_ZERO;
                end
                READ: begin
                    write_r <= 1'b0;
                    if (cnt_r < CNT_LAST) begin
                        raddr_r <= {dir_r, IDX_W'(cnt_r + CNT_ONE)};
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else begin
                        read_r  <= 1'b0;
                        state_r <= FLUSH;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                FLUSH: begin
                    write_r <= 1'b0;
                    if (cnt_r == CNT_TWO) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SEED: begin
                    if (cnt_r < CNT_ROW) begin
                        write_r <= 1'b1;
                        waddr_r <= {~dir_r, IDX_W'(cnt_r)};
                        wdata_r <= seed_word(cnt_r);
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else begin
                        write_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase

            // Datapath; these assignments take precedence over the FSM defaults.
            if (pre_arr_s) begin
                left_r <= wrap_r & ram.rdata[WORD_W-1];
            end else if (first_arr_s) begin
                cur_r   <= ram.rdata;
                word0_r <= ram.rdata;
            end else if (arr_s) begin
                // rdata holds word k: word k-1 is now complete.
                write_r <= 1'b1;
                waddr_r <= {~dir_r, wr_idx_s};
                wdata_r <= new_word_s;
                left_r  <= cur_r[WORD_W-1];
                cur_r   <= ram.rdata;
            end else if (fin_s) begin
                write_r <= 1'b1;
                waddr_r <= {~dir_r, wr_idx_s};
                wdata_r <= new_word_s;
            end else begin
                left_r <= left_r;
            end
        end
    end

    assign ram.read  = read_r;
    assign ram.raddr = raddr_r;
    assign ram.write = write_r;
    assign ram.waddr = waddr_r;
    assign ram.wdata = wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_ca_rule_gen.sv
// ----------------------------------------------------------------------------
// tb_ca_rule_gen: directed bench for ca_rule_gen with WORD_W=16, ROW_WORDS=4,
// ADDR_W=10 and a behavioural 1-cycle RAM that logs every read and write.
// ----------------------------------------------------------------------------
module tb_ca_rule_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       direction;
    logic       seed;
    logic [7:0] rule;
    logic       wrap;
    logic       busy;
    logic       done;

    ca_rule_gen_if #(.WORD_W(16), .ADDR_W(10)) ram ();

    ca_rule_gen #(
        .WORD_W    (16),
        .ROW_WORDS (4),
        .ADDR_W    (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .direction (direction),
        .seed      (seed),
        .rule      (rule),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done),
        .ram       (ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;

    int          cyc = 0;
    logic [8:0]  wr_n = 9'd0;
    logic [8:0]  rd_n = 9'd0;
    int          wr_cyc  [0:511];
    logic [9:0]  wr_addr [0:511];
    logic [15:0] wr_data [0:511];
    int          rd_cyc  [0:511];
    logic [9:0]  rd_addr [0:511];

    int n_checks = 0;
    int n_errors = 0;

    // RAM model with logging; cyc is the number of the cycle ending at this edge.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram.write) mem[ram.waddr] <= ram.wdata;
        if (ram.read) begin
            ram.rdata     <= mem[ram.raddr];
            rd_cyc[rd_n]  <= cyc;
            rd_addr[rd_n] <= ram.raddr;
            rd_n          <= rd_n + 9'd1;
        end
        if (ram.write) begin
            wr_cyc[wr_n]  <= cyc;
            wr_addr[wr_n] <= ram.waddr;
            wr_data[wr_n] <= ram.wdata;
            wr_n          <= wr_n + 9'd1;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] base, input logic [63:0] row);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = base + 10'(i);
            pl_data = row[16*i +: 16];
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Pulse start for cycle T, then scramble the sampled inputs from T+1 on.
    task automatic do_start(input logic d, input logic s, input logic [7:0] r,
                            input logic w, output int t0);
        @(negedge clk);
        direction = d; seed = s; rule = r; wrap = w; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0; direction = ~d; seed = ~s; rule = ~r; wrap = ~w;
    endtask

    // Observe a fixed window starting at T+1.
    task automatic watch(output int done_at, output int busy_n, output int done_n);
        done_at = -1; busy_n = 0; done_n = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
            @(negedge clk);
        end
    endtask

    // One full run with expected destination row {w3,w2,w1,w0}.
    task automatic run(input string tag, input logic d, input logic s, input logic [7:0] r,
                       input logic w, input logic [63:0] exp_row, output int t0);
        logic [8:0] wb, rb, idx;
        int done_at, busy_n, done_n, wr_off;
        wb = wr_n; rb = rd_n;
        do_start(d, s, r, w, t0);
        watch(done_at, busy_n, done_n);
        wr_off = s ? 1 : 5;
        check({tag, " done_at"}, 64'(done_at - t0), s ? 64'd5 : 64'd9);
        check({tag, " done_pulses"}, 64'(done_n), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_n), s ? 64'd4 : 64'd8);
        check({tag, " write_count"}, 64'(int'(wr_n - wb)), 64'd4);
        check({tag, " read_count"}, 64'(int'(rd_n - rb)), s ? 64'd0 : 64'd5);
        for (int i = 0; i < 4; i++) begin
            idx = wb + 9'(i);
            check($sformatf("%s wr%0d_cycle", tag, i), 64'(wr_cyc[idx] - t0), 64'(wr_off + i));
            check($sformatf("%s wr%0d_addr", tag, i), 64'(wr_addr[idx]), 64'({~d, 9'(i)}));
            check($sformatf("%s wr%0d_data", tag, i), 64'(wr_data[idx]), 64'(exp_row[16*i +: 16]));
        end
        if (!s) begin
            check({tag, " prefetch_cycle"}, 64'(rd_cyc[rb] - t0), 64'd1);
            check({tag, " prefetch_addr"}, 64'(rd_addr[rb]), 64'({d, 9'd3}));
            for (int i = 0; i < 4; i++) begin
                idx = rb + 9'(i + 1);
                check($sformatf("%s rd%0d_cycle", tag, i), 64'(rd_cyc[idx] - t0), 64'(2 + i));
                check($sformatf("%s rd%0d_addr", tag, i), 64'(rd_addr[idx]), 64'({d, 9'(i)}));
            end
        end
    endtask

    initial begin
        int t0, t1, done_at, busy_n, done_n;
        logic [8:0] wb;
        rst = 1'b1; start = 1'b0; direction = 1'b0; seed = 1'b0; rule = 8'd0; wrap = 1'b0;
        pl_en = 1'b0; pl_addr = 10'd0; pl_data = 16'd0;
        repeat (3) @(negedge clk);
        check("reset read", 64'(ram.read), 64'd0);
        check("reset write", 64'(ram.write), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset raddr", 64'(ram.raddr), 64'd0);
        check("reset waddr", 64'(ram.waddr), 64'd0);
        check("reset wdata", 64'(ram.wdata), 64'd0);
        rst = 1'b0;

        // Seed into bank 1, then rule 90 from bank 1 into bank 0.
        run("seed", 1'b0, 1'b1, 8'd0, 1'b0, 64'h0000_0001_0000_0000, t0);
        run("r90_seed", 1'b1, 1'b0, 8'd90, 1'b1, 64'h0000_0002_8000_0000, t0);

        // Only cell 0 live: right-end wrap.
        preload(10'd0, 64'h0000_0000_0000_0001);
        run("r90_c0_wrap", 1'b0, 1'b0, 8'd90, 1'b1, 64'h8000_0000_0000_0002, t0);
        run("r90_c0_zero", 1'b0, 1'b0, 8'd90, 1'b0, 64'h0000_0000_0000_0002, t0);

        // Only cell 63 live: left-end wrap.
        preload(10'd0, 64'h8000_0000_0000_0000);
        run("r90_c63_wrap", 1'b0, 1'b0, 8'd90, 1'b1, 64'h4000_0000_0000_0001, t0);
        run("r90_c63_zero", 1'b0, 1'b0, 8'd90, 1'b0, 64'h4000_0000_0000_0000, t0);

        // Cells 0 and 63 live: asymmetric rules (240 copies L, 170 copies R).
        preload(10'd0, 64'h8000_0000_0000_0001);
        run("r240", 1'b0, 1'b0, 8'd240, 1'b1, 64'h0000_0000_0000_0003, t0);
        run("r170", 1'b0, 1'b0, 8'd170, 1'b1, 64'hC000_0000_0000_0000, t0);

        // Arbitrary rows: identity, all ones, all zeros.
        preload(10'd0, 64'h0F0F_FFFF_1234_A5C3);
        run("r204_wrap", 1'b0, 1'b0, 8'd204, 1'b1, 64'h0F0F_FFFF_1234_A5C3, t0);
        run("r204_zero", 1'b0, 1'b0, 8'd204, 1'b0, 64'h0F0F_FFFF_1234_A5C3, t0);
        run("r255", 1'b0, 1'b0, 8'd255, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, t0);
        run("r0", 1'b0, 1'b0, 8'd0, 1'b1, 64'h0000_0000_0000_0000, t0);

        // start pulsed at T+3 during a seed run into bank 0 is ignored.
        wb = wr_n;
        do_start(1'b1, 1'b1, 8'd0, 1'b0, t0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(done_at, busy_n, done_n);
        check("ignore done_pulses", 64'(done_n), 64'd1);
        check("ignore done_at", 64'(done_at - t0), 64'd5);
        check("ignore write_count", 64'(int'(wr_n - wb)), 64'd4);
        check("ignore busy_end", 64'(busy), 64'd0);

        // Reset at T+6 of a compute run from bank 0 (seed row) into bank 1.
        wb = wr_n;
        do_start(1'b0, 1'b0, 8'd204, 1'b1, t0);
        for (int k = 0; k < 20 && cyc < t0 + 6; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst read", 64'(ram.read), 64'd0);
        check("midrst write", 64'(ram.write), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst raddr", 64'(ram.raddr), 64'd0);
        check("midrst waddr", 64'(ram.waddr), 64'd0);
        check("midrst wdata", 64'(ram.wdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst write_count", 64'(int'(wr_n - wb)), 64'd2);
        check("midrst last_write_cycle", 64'(wr_cyc[wb + 9'd1] - t0), 64'd6);
        run("restart", 1'b0, 1'b0, 8'd204, 1'b1, 64'h0000_0001_0000_0000, t1);
        check("restart start_cycle", 64'(t1 - t0), 64'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
